alu_chain_seq: RTL and testbench
================================

# alu_chain_seq

Multi-cycle sequencer that performs WORDS×N-bit add, subtract, AND and OR operations by driving one shared N-bit ALU datapath once per word, least-significant word first. It chains the carry between words and accumulates the zero flag. It produces final v/c/n/z flags with the same semantics as the single-word flag logic. It sits between the instruction-level control and the N-bit ALU, so wide operands never need a wide adder.

## Interface
Parameters:
- N, 32, width of one ALU word.
- WORDS, 4, number of words per operand (≥2); wide width W = N*WORDS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new operation; sampled only in IDLE.
- m  in  2  operation: 00 add, 01 subtract (a−b), 10 AND, 11 OR.
- a  in  W  wide operand A; sampled with start.
- b  in  W  wide operand B; sampled with start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  W  wide result; held until the next accepted start.
- v, c, n, z  out  1 each  overflow, carry, negative and zero flags; held with result.
- alu_m  out  2  mode to the shared ALU (latched m).
- alu_a, alu_b  out  N each  current word of latched a/b.
- alu_cin  out  1  carry-in to the ALU for the current word.
- alu_r  in  N  ALU result for the current word (combinational from alu_*).
- alu_cout  in  1  ALU carry-out for the current word.

## Operation
- FSM states:
  - IDLE: start=1 latches a, b and m, clears idx, the carry register and the result register, sets zacc=1, and moves to RUN. start=0 stays in IDLE.
  - RUN: drives word idx. alu_a = a_l[idx*N +: N], alu_b = b_l[idx*N +: N], alu_m = m_l.
    - alu_cin = m_l[0] when idx=0, else the carry register. When m_l[1]=1, alu_cin = 0.
    - Each cycle: result[idx*N +: N] ← alu_r; carry ← alu_cout; zacc ← zacc & (alu_r==0); idx ← idx+1.
    - When idx=WORDS−1, the FSM also registers the flags and moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy. No queueing and no error indication.
- Flags are computed from the final word, with aM=a_l[W−1], bM=b_l[W−1], rM=alu_r[N−1]:
  - v = ~m[1] & (aM ^ rM) & ~(aM ^ bM ^ m[0]).
  - c = ~m[1] & alu_cout. For subtract, c=1 means no borrow.
  - n = rM.
  - z = zacc & (alu_r==0), i.e. all W result bits are zero.
- For logic ops (m[1]=1), v and c are 0. n and z follow the result.
- Arithmetic is modulo 2^W. The carry out of the top word is not kept beyond c.
- alu_* outputs are don't-care outside RUN but must not be X. Drive the latched values with idx=0.

## Timing
- Reset (asynchronous, rst_n=0) sets state=IDLE and busy=0, done=0. result, v, c, n, z, idx, carry and the latched operands all go to 0, and zacc goes to 1.
- Reset mid-operation aborts immediately. No done pulse follows and the partial result is discarded (zeroed).
- Cycle 0: start sampled high in IDLE.
- Cycles 1..WORDS: RUN, one word per cycle. busy=1 from cycle 1.
- Cycle WORDS+1: DONE, done=1, busy=1, and result and flags are final.
- Cycle WORDS+2: IDLE, busy=0. A start sampled here begins the next operation. Throughput is one operation per WORDS+2 cycles.
- Latency from start to done is WORDS+1 cycles.
- result words update progressively during RUN. Only the value at and after done is architecturally valid.
- The ALU path alu_* → alu_r/alu_cout is combinational within one cycle and is the critical path.

## Test plan
All scenarios use N=8, WORDS=2 (16-bit) and a behavioural N-bit ALU model: r = a + (b^{N{m0}}) + cin for arithmetic, AND/OR for logic.
- Add across the word boundary: m=00, a=0x00FF, b=0x0001 → result=0x0100, v=0 c=0 n=0 z=0. done exactly 3 cycles after start, and alu_cin=1 in the second RUN cycle.
- Subtract with borrow: m=01, a=0x0000, b=0x0001 → result=0xFFFF, c=0 n=1 z=0 v=0.
- Signed overflow: m=00, a=0x7FFF, b=0x0001 → result=0x8000, v=1 n=1 c=0 z=0.
- Equal subtract: m=01, a=0x1234, b=0x1234 → result=0x0000, z=1 c=1 v=0 n=0.
- Logic op plus busy-ignore: m=10, a=0xF0F0, b=0x0FF0 → result=0x00F0, v=0 c=0 n=0 z=0. A second start pulsed during RUN produces no extra done and does not alter result. Then m=11 on the same operands → 0xFFF0, n=1.
- Reset mid-run: pull rst_n low during the first RUN cycle → busy=0, done=0, result=0 and all flags 0 immediately. No done pulse follows after release. A new start then completes normally.

Source files
------------

// File: rtl/alu_chain_seq.sv
// ---------------------------------------------------------------------------
// alu_chain_seq
// Multi-cycle sequencer that runs a WORDS x N-bit add/sub/AND/OR through one
// shared N-bit ALU, one word per cycle, least-significant word first. The
// carry is chained between words and the zero flag is accumulated, so the
// final v/c/n/z match what a single W-bit ALU would report.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request an operation (only honoured in IDLE)
//   m[1:0]              00 add, 01 subtract (a-b), 10 AND, 11 OR
//   a, b [W-1:0]        wide operands, latched with start
//   busy                high whenever not IDLE
//   done                one-cycle pulse, result/flags valid from here on
//   result [W-1:0]      wide result, held until the next accepted start
//   v, c, n, z          overflow, carry (1 = no borrow on sub), negative, zero
//   alu_m, alu_a, alu_b, alu_cin   drive to the shared N-bit ALU
//   alu_r, alu_cout                combinational answer from the ALU
// ---------------------------------------------------------------------------
module alu_chain_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           m,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 v,
    output logic                 c,
    output logic                 n,
    output logic                 z,
    output logic [1:0]           alu_m,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic                 alu_cin,
    input  logic [N-1:0]         alu_r,
    input  logic                 alu_cout
);

    localparam int unsigned W     = N * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    // Latched operation and operands, viewed as an array of ALU words
    logic [WORDS-1:0][N-1:0]  r_a_l;
    logic [WORDS-1:0][N-1:0]  r_b_l;
    logic [1:0]               r_m_l;
    logic [WORDS-1:0][N-1:0]  r_result;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_carry;
    logic                     r_zacc;

    logic                     r_busy;
    logic                     r_done;
    logic                     r_v;
    logic                     r_c;
    logic                     r_n;
    logic                     r_z;

    logic                     w_accept;
    logic                     w_step;
    logic                     w_last;
    logic                     w_word_zero;
    logic [1:0]               w_alu_m;
    logic [N-1:0]             w_alu_a;
    logic [N-1:0]             w_alu_b;
    logic                     w_alu_cin;
    logic                     w_a_msb;
    logic                     w_b_msb;
    logic                     w_r_msb;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath-control decode; idx is 0 outside RUN so the ALU
    // drive stays at word 0 of the latched (never X) operands.
    always_comb begin
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_alu_m     = r_m_l;
        w_alu_a     = r_a_l[r_idx];
        w_alu_b     = r_b_l[r_idx];
        w_alu_cin   = 1'b0;
        w_word_zero = (alu_r == '0);
        w_a_msb     = r_a_l[WORDS-1][N-1];
        w_b_msb     = r_b_l[WORDS-1][N-1];
        w_r_msb     = alu_r[N-1];

        // Word 0 takes the subtract "+1"; later words take the chained carry
        if (!r_m_l[1]) begin
            w_alu_cin = (r_idx == '0) ? r_m_l[0] : r_carry;
        end

        case (r_state)
            S_IDLE: w_accept = start;
            S_RUN: begin
                w_step = 1'b1;
                w_last = (r_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

    // Control outputs registered so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_last;
        end
    end

    // Operand latch, per-word result capture, carry chain and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_l    <= '0;
            r_b_l    <= '0;
            r_m_l    <= 2'b00;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b1;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else if (w_accept) begin
            r_a_l    <= a;
            r_b_l    <= b;
            r_m_l    <= m;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b1;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else if (w_step) begin
            r_result[r_idx] <= alu_r;
            r_carry         <= alu_cout;
            r_zacc          <= r_zacc & w_word_zero;
            if (w_last) begin
                // Park idx at 0 so the ALU drive is word 0 while idle
                r_idx <= '0;
                r_v   <= ~r_m_l[1] & (w_a_msb ^ w_r_msb)
                         & ~(w_a_msb ^ w_b_msb ^ r_m_l[0]);
                r_c   <= ~r_m_l[1] & alu_cout;
                r_n   <= w_r_msb;
                r_z   <= r_zacc & w_word_zero;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = W'(r_result);
    assign v       = r_v;
    assign c       = r_c;
    assign n       = r_n;
    assign z       = r_z;
    assign alu_m   = w_alu_m;
    assign alu_a   = w_alu_a;
    assign alu_b   = w_alu_b;
    assign alu_cin = w_alu_cin;

endmodule

// File: tb/tb_alu_chain_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_chain_seq
// Bench for alu_chain_seq at N=8, WORDS=2 with a behavioural 8-bit ALU.
// A wide-arithmetic reference model predicts busy/done/result/flags every
// cycle; directed vectors pin that model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_alu_chain_seq;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 2;
    localparam int unsigned W     = N * WORDS;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     m     = 2'b00;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           v;
    logic           c;
    logic           n;
    logic           z;
    logic [1:0]     alu_m;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic           alu_cin;
    logic [N-1:0]   alu_r;
    logic           alu_cout;
    logic [N:0]     alu_sum;

    int errors     = 0;
    int checks     = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    alu_chain_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .m        (m),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .v        (v),
        .c        (c),
        .n        (n),
        .z        (z),
        .alu_m    (alu_m),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_r    (alu_r),
        .alu_cout (alu_cout)
    );

    // Behavioural single-word ALU
    assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b ^ {N{alu_m[0]}}} + {{N{1'b0}}, alu_cin};
    assign alu_r    = alu_m[1] ? (alu_m[0] ? (alu_a | alu_b) : (alu_a & alu_b)) : alu_sum[N-1:0];
    assign alu_cout = ~alu_m[1] & alu_sum[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-operation reference: {v, c, n, z, result[15:0]}
    function automatic logic [19:0] model_op(input logic [1:0] mm, input logic [15:0] aa,
                                              input logic [15:0] bb);
        logic [15:0] r;
        logic        fv;
        logic        fc;
        int          sa;
        int          sb;
        int          full;
        sa   = int'($signed(aa));
        sb   = int'($signed(bb));
        full = 0;
        fv   = 1'b0;
        fc   = 1'b0;
        case (mm)
            2'b00: begin
                r    = aa + bb;
                full = sa + sb;
                fc   = (int'(aa) + int'(bb)) > 65535;
            end
            2'b01: begin
                r    = aa - bb;
                full = sa - sb;
                fc   = (aa >= bb);
            end
            2'b10:   r = aa & bb;
            default: r = aa | bb;
        endcase
        if (!mm[1]) fv = (full > 32767) || (full < -32768);
        return {fv, fc, r[15], (r == 16'h0000), r};
    endfunction

    // Timing model: mdl_cnt = cycles since the accepted start (0 = idle)
    int          mdl_cnt   = 0;
    logic [15:0] mdl_res   = '0;
    logic [3:0]  mdl_flags = '0;
    logic [19:0] mdl_pend  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt   <= 0;
            mdl_res   <= '0;
            mdl_flags <= '0;
        end else if (mdl_cnt == 0) begin
            if (start) begin
                mdl_pend <= model_op(m, a, b);
                mdl_cnt  <= 1;
            end
        end else if (mdl_cnt == int'(WORDS)) begin
            mdl_res   <= mdl_pend[15:0];
            mdl_flags <= mdl_pend[19:16];
            mdl_cnt   <= mdl_cnt + 1;
        end else if (mdl_cnt == int'(WORDS) + 1) begin
            mdl_cnt <= 0;
        end else begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", busy, (mdl_cnt != 0));
        chk("done", done, (mdl_cnt == int'(WORDS) + 1));
        if (done === 1'b1) done_count++;
        if (mdl_cnt == 0 || mdl_cnt == int'(WORDS) + 1) begin
            chk("result", result, mdl_res);
            chk("flags_vcnz", {v, c, n, z}, mdl_flags);
        end
        if (mdl_cnt == 0) chk("alu_known", $isunknown({alu_m, alu_a, alu_b, alu_cin}), 0);
    end

    // One operation with literal expectations; flags are {v,c,n,z}
    task automatic run_op(input string nm, input logic [1:0] mm, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [15:0] er, input logic [3:0] ef,
                          input bit poke, input bit cin_chk);
        int cyc;
        int d0;
        @(negedge clk);
        m     = mm;
        a     = aa;
        b     = bb;
        start = 1'b1;
        d0    = done_count;
        @(negedge clk);
        start = poke;   // a start seen during RUN must be ignored
        cyc   = 1;
        while (done !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cin_chk && cyc == 2) chk({nm, "_cin_word1"}, alu_cin, 1);
        end
        chk({nm, "_latency"}, cyc, 3);
        chk({nm, "_result"}, result, er);
        chk({nm, "_flags"}, {v, c, n, z}, ef);
        chk({nm, "_model_result"}, mdl_res, er);
        chk({nm, "_model_flags"}, mdl_flags, ef);
        repeat (3) @(negedge clk);
        chk({nm, "_done_pulses"}, done_count - d0, 1);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_held_result"}, result, er);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", {v, c, n, z}, 4'b0000);

        run_op("add_carry", 2'b00, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 1'b0, 1'b1);
        run_op("sub_borrow", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 1'b0, 1'b0);
        run_op("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1'b0, 1'b0);
        run_op("sub_equal", 2'b01, 16'h1234, 16'h1234, 16'h0000, 4'b0101, 1'b0, 1'b0);
        run_op("and_poke", 2'b10, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1, 1'b0);
        run_op("or", 2'b11, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0010, 1'b0, 1'b0);

        // Reset during the first RUN cycle
        @(negedge clk);
        m     = 2'b00;
        a     = 16'h00FF;
        b     = 16'h0001;
        start = 1'b1;
        d0    = done_count;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy_before_rst", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 16'h0000);
        chk("mid_rst_flags", {v, c, n, z}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", done_count - d0, 0);
        chk("mid_rst_idle", busy, 0);

        run_op("post_rst_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
